// File: rtl/fp_round_pack.sv
// -----------------------------------------------------------------------------
// fp_round_pack
// Final rounding and packing stage of an IEEE-754 floating-point datapath. It
// takes a normalized significand with guard/round/sticky bits and a biased
// exponent plus adjustment from the normalizer. It rounds, renormalizes,
// detects overflow/underflow and packs the sign/exponent/fraction result.
//
// Two-register pipeline:
//   S1 : exponent adjust, inexact detection, round-increment decision
//   S2 : significand increment, carry renormalize, special cases, pack
//
// Configuration macro: FP_ROUND_MODES_EN
//   defined   -> all RISC-V rounding modes (RNE/RTZ/RDN/RUP/RMM); 5..7 act as RNE
//   undefined -> in_rm ignored, always RNE, overflow always to infinity
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   in_valid/ready  : upstream handshake
//   in_sign         : result sign
//   in_exp          : pre-normalization biased exponent
//   in_shift        : two's-complement exponent adjustment
//   in_sig          : {hidden, fraction, G, R, S}
//   in_rm           : rounding mode
//   out_valid/ready : downstream handshake
//   out_result      : packed {sign, exponent, fraction}
//   out_flags       : {NV, DZ, OF, UF, NX} for this result
//   fflags_acc      : sticky OR of flags of every accepted result
//   fflags_clr      : clears fflags_acc (wins over a same-cycle update)
// -----------------------------------------------------------------------------
module fp_round_pack #(
   parameter int SIG_BITS = 23,
   parameter int EXP_BITS = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sign,
   input  logic [EXP_BITS-1:0]          in_exp,
   input  logic [EXP_BITS-1:0]          in_shift,
   input  logic [SIG_BITS+3:0]          in_sig,
   input  logic [2:0]                   in_rm,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [EXP_BITS+SIG_BITS:0]   out_result,
   output logic [4:0]                   out_flags,
   output logic [4:0]                   fflags_acc,
   input  logic                         fflags_clr
);

   // Two extra bits hold the full range of in_exp + in_shift plus a sign.
   localparam int EW = EXP_BITS + 2;
   localparam logic [EW-1:0] EXP_INF = EW'((1 << EXP_BITS) - 1);

   localparam int FLAG_NX = 0;
   localparam int FLAG_UF = 1;
   localparam int FLAG_OF = 2;

   // ---------------------------------------------------------------- S1 comb
   logic          g_bit, r_bit, s_bit, lsb_bit;
   logic          nx, rne_inc, round_inc, ovf_to_max;
   logic [EW-1:0] e_adj;

   assign lsb_bit = in_sig[3];
   assign g_bit   = in_sig[2];
   assign r_bit   = in_sig[1];
   assign s_bit   = in_sig[0];
   assign nx      = g_bit | r_bit | s_bit;
   assign rne_inc = g_bit & (r_bit | s_bit | lsb_bit);
   assign e_adj   = {2'b00, in_exp} + {{2{in_shift[EXP_BITS-1]}}, in_shift};

`ifdef FP_ROUND_MODES_EN
   typedef enum logic [2:0] {
      RM_RNE = 3'd0,
      RM_RTZ = 3'd1,
      RM_RDN = 3'd2,
      RM_RUP = 3'd3,
      RM_RMM = 3'd4
   } rm_e;
`else
   logic unused_rm;
   assign unused_rm = ^in_rm;
`endif

   // ovf_to_max: the mode rounds toward zero for this sign, so an overflow
   // saturates to the largest finite value instead of infinity.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      round_inc  = rne_inc;
      ovf_to_max = 1'b0;
`ifdef FP_ROUND_MODES_EN
      case (in_rm)
         RM_RTZ: begin
            round_inc  = 1'b0;
            ovf_to_max = 1'b1;
         end
         RM_RDN: begin
            round_inc  = nx & in_sign;
            ovf_to_max = !in_sign;
         end
         RM_RUP: begin
            round_inc  = nx & !in_sign;
            ovf_to_max = in_sign;
         end
         RM_RMM:  round_inc = g_bit;
         default: ;  // RNE and the reserved encodings
      endcase
`endif
   end

   // ---------------------------------------------------------------- handshake
   logic s1_valid, s1_adv;

   assign s1_adv   = !out_valid | out_ready;
   assign in_ready = !s1_valid | s1_adv;

   // ---------------------------------------------------------------- S1 regs
   logic                s1_sign, s1_inc, s1_nx, s1_zero, s1_ovf_max;
   logic [EW-1:0]       s1_e;
   logic [SIG_BITS:0]   s1_mant;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else if (in_ready) begin
         // NOTE: sequential state is always written with non-blocking
         // assignments so every register samples pre-edge values.
         s1_valid <= in_valid;
      end
   end

   // NOTE: payload registers have no reset; s1_valid qualifies them, so
   // their power-up contents are never observed.
   always_ff @(posedge clk) begin
      if (in_ready && in_valid) begin
         s1_sign    <= in_sign;
         s1_e       <= e_adj;
         s1_mant    <= in_sig[SIG_BITS+3:3];
         s1_inc     <= round_inc;
         s1_nx      <= nx;
         s1_zero    <= (in_sig == '0);
         s1_ovf_max <= ovf_to_max;
      end
   end

   // ---------------------------------------------------------------- S2 comb
   logic [SIG_BITS+1:0]        sum;
   logic                       carry, overflow, e_nonpos;
   logic [SIG_BITS:0]          mant;
   logic [EW-1:0]              e_rnd;
   logic [EXP_BITS-1:0]        exp_field;
   logic [EXP_BITS+SIG_BITS:0] res_next;
   logic [4:0]                 flags_next;

   assign sum      = {1'b0, s1_mant} + {{(SIG_BITS+1){1'b0}}, s1_inc};
   assign carry    = sum[SIG_BITS+1];
   assign mant     = carry ? sum[SIG_BITS+1:1] : sum[SIG_BITS:0];
   assign e_rnd    = s1_e + {{(EW-1){1'b0}}, carry};
   assign overflow = $signed(e_rnd) >= $signed(EXP_INF);
   assign e_nonpos = e_rnd[EW-1] || (e_rnd == '0);

   // A denormal whose rounding reaches the hidden bit becomes the smallest
   // normal, so the exponent field follows the hidden bit there.
   assign exp_field = e_nonpos ? {{(EXP_BITS-1){1'b0}}, mant[SIG_BITS]}
                               : e_rnd[EXP_BITS-1:0];

   always_comb begin
      res_next   = {s1_sign, exp_field, mant[SIG_BITS-1:0]};
      flags_next = '0;
      flags_next[FLAG_NX] = s1_nx;
      if (s1_zero) begin
         res_next   = {s1_sign, {(EXP_BITS+SIG_BITS){1'b0}}};
         flags_next = '0;
      end else if (overflow) begin
         flags_next[FLAG_OF] = 1'b1;
         flags_next[FLAG_NX] = 1'b1;
         if (s1_ovf_max)
            res_next = {s1_sign, {{(EXP_BITS-1){1'b1}}, 1'b0}, {SIG_BITS{1'b1}}};
         else
            res_next = {s1_sign, {EXP_BITS{1'b1}}, {SIG_BITS{1'b0}}};
      end else if (exp_field == '0 && s1_nx) begin
         flags_next[FLAG_UF] = 1'b1;
      end
   end

   // ---------------------------------------------------------------- S2 regs
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else if (s1_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= res_next;
            out_flags  <= flags_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || fflags_clr)
         fflags_acc <= '0;
      else if (out_valid && out_ready)
         fflags_acc <= fflags_acc | out_flags;
   end

endmodule
